// File: rtl/dac_rnm_if.sv
// Code handshake between a sender and the DAC model.
// A code transfers on a clock edge where din_valid and din_ready are both high.
interface dac_rnm_if #(
  parameter int N = 10
) ();
  logic [N-1:0] din;
  logic         din_valid;
  logic         din_ready;

  modport master (output din, output din_valid, input din_ready);
  modport slave  (input din, input din_valid, output din_ready);
endinterface

// File: rtl/dac_rnm.sv
// Real-number model of an N-bit binary-weighted DAC with static per-bit mismatch.
// Accept at E0, linear ramp reaches the target at E_SETTLE_CYC; din_ready is low while settling.
module dac_rnm #(
  parameter int  N              = 10,
  parameter real vrefp          = 1.0,
  parameter real vrefn          = 0.0,
  parameter real mismatch_sigma = 0.002,
  parameter int  SETTLE_CYC     = 4,
  parameter int  SEED           = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  dac_rnm_if.slave i_bus,
  output real      o_vout,
  output logic     o_busy,
  output logic     o_settled
);
  localparam int CW = $clog2(SETTLE_CYC + 1);

  typedef enum logic {IDLE, SETTLE} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          w_accept;
  logic [N-1:0]  r_code;
  logic [CW-1:0] r_cnt;
  real           r_vout;
  real           r_start;
  real           w_target;
  real           w_weight_mis [N];

  // Draw number idx of the seeded normal sequence; restarting from SEED keeps every bit's error fixed.
  function automatic real nth_gauss(input int idx);
    int s;
    int d;
    s = SEED;
    d = 0;
    for (int k = 0; k <= idx; k++) begin
      d = $dist_normal(s, 0, 1000000);
    end
    return real'(d) * 1.0e-6;
  endfunction

  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_weight_mis[i] = ((vrefp - vrefn) / (2.0 ** (N - i))) *
                        (1.0 + mismatch_sigma * nth_gauss(i));
    end
  end

  always_comb begin
    w_target = vrefn;
    for (int i = 0; i < N; i++) begin
      if (r_code[i]) begin
        w_target = w_target + w_weight_mis[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_accept        = 1'b0;
    i_bus.din_ready = 1'b0;
    o_busy          = 1'b0;
    o_settled       = 1'b0;
    case (r_state)
      IDLE: begin
        i_bus.din_ready = 1'b1;
        o_settled       = 1'b1;
        if (i_bus.din_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        o_busy = 1'b1;
        if (r_cnt == CW'(SETTLE_CYC - 1)) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // The target follows the captured code; the last step assigns it so no rounding error accumulates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_code  <= '0;
      r_cnt   <= '0;
      r_vout  <= vrefn;
      r_start <= vrefn;
    end else if (w_accept) begin
      r_code  <= i_bus.din;
      r_cnt   <= '0;
      r_start <= r_vout;
    end else if (r_state == SETTLE) begin
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == CW'(SETTLE_CYC - 1)) begin
        r_vout <= w_target;
      end else begin
        r_vout <= r_start + (w_target - r_start) * real'(int'(r_cnt) + 1) / real'(SETTLE_CYC);
      end
    end
  end

  assign o_vout = r_vout;
endmodule
